// File: rtl/matmul_2x2_seq_ctrl.sv
// Sequenced 2x2 A^T / A*A^T unit: one shared DW x DW multiplier and one accumulator
// stepped over the MAC loop (k innermost, then j, then i), valid/ready on both sides.
module matmul_2x2_seq_ctrl #(
    parameter int DW      = 4,
    parameter bit USE_SYM = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4*DW-1:0] in_mat,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4*DW-1:0] out_trans,
    output logic [4*DW-1:0] out_prod,
    output logic            busy
);
    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

    state_t          r_state;
    logic [4*DW-1:0] r_a;
    logic [2*DW:0]   r_acc;
    logic            r_i, r_j, r_k;
    logic            r_out_valid;
    logic [4*DW-1:0] r_trans;
    logic [4*DW-1:0] r_prod;

    // Packed slot of element [r][c] is 3-(2r+c), i.e. the bitwise inverse of {r,c}.
    function automatic logic [DW-1:0] elem(input logic [4*DW-1:0] m, input logic [1:0] idx);
        return m[int'(idx)*DW +: DW];
    endfunction

    logic [DW-1:0] w_aik, w_ajk;
    logic [2*DW:0] w_mul, w_acc_next;
    logic [1:0]    w_pidx;
    logic          w_last;

    assign w_aik      = elem(r_a, ~{r_i, r_k});
    assign w_ajk      = elem(r_a, ~{r_j, r_k});
    assign w_mul      = {{(DW+1){1'b0}}, w_aik} * {{(DW+1){1'b0}}, w_ajk};
    assign w_acc_next = (r_k ? r_acc : '0) + w_mul;
    assign w_pidx     = ~{r_i, r_j};
    assign w_last     = r_i & r_j & r_k;

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign out_trans = r_trans;
    assign out_prod  = r_prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_acc       <= '0;
            r_i         <= 1'b0;
            r_j         <= 1'b0;
            r_k         <= 1'b0;
            r_out_valid <= 1'b0;
            r_trans     <= '0;
            r_prod      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_mat;
                        r_trans <= {in_mat[3*DW +: DW], in_mat[DW +: DW],
                                    in_mat[2*DW +: DW], in_mat[0 +: DW]};
                        r_i     <= 1'b0;
                        r_j     <= 1'b0;
                        r_k     <= 1'b0;
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc <= w_acc_next;
                    if (!r_k) begin
                        r_k <= 1'b1;
                    end else begin
                        r_k <= 1'b0;
                        r_prod[int'(w_pidx)*DW +: DW] <= w_acc_next[DW-1:0];
                        if (w_last) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            // Symmetric mode never computes p10; mirror p01 into it.
                            if (USE_SYM) r_prod[DW +: DW] <= r_prod[2*DW +: DW];
                        end else if (!r_j) begin
                            r_j <= 1'b1;
                        end else begin
                            r_i <= 1'b1;
                            r_j <= USE_SYM;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
